// File: rtl/dfd_dst_pkg.sv
// Shared definitions for the debug-signal-trace (DST) block family.
//   VLT_PACKET_WIDTH : width in bits of one VLT packet on the packetizer ingress
//   DST_ARB_MAX_SRC  : largest number of trace generators one arbiter may serve
//   req_bytes_width  : width of a "requested space in bytes" field for a given
//                      packet width (must be able to express a full packet)
package dfd_dst_pkg;

  localparam int VLT_PACKET_WIDTH = 64;
  localparam int DST_ARB_MAX_SRC  = 16;

  function automatic int req_bytes_width(input int packet_width);
    return $clog2(packet_width / 8) + 1;
  endfunction

endpackage

// File: rtl/dfd_rr_pick.sv
// Round-robin picker with a priority-override vector.
//   req       : request vector
//   ptr       : round-robin start index (search begins here, wraps cyclically)
//   prio      : override vector; any requester with prio set wins first,
//               lowest index among them
//   grant_oh  : one-hot winner (all zero when nothing requests)
//   grant_idx : binary index of the winner (0 when nothing requests)
//   valid     : a winner exists
// Purely combinational. Selection is kept in lowest-bit-set form
// (x & -x) so the path into the packetizer grant stays short.
module dfd_rr_pick #(
  parameter int N     = 4,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  input  logic [N-1:0]     prio,
  output logic [N-1:0]     grant_oh,
  output logic [PTR_W-1:0] grant_idx,
  output logic             valid
);

  logic [N-1:0] prio_req;
  logic [N-1:0] upper_mask;
  logic [N-1:0] upper_req;
  logic [N-1:0] cand;

  always_comb begin
    prio_req   = req & prio;
    // Bits at or above ptr; requests there win before the wrapped-around ones.
    upper_mask = ~((N'(1) << ptr) - N'(1));
    upper_req  = req & upper_mask;

    if (|prio_req) begin
      cand = prio_req;
    end else if (|upper_req) begin
      cand = upper_req;
    end else begin
      cand = req;
    end

    grant_oh = cand & (~cand + N'(1));
    valid    = |req;

    grant_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_oh[i]) begin
        grant_idx = grant_idx | PTR_W'(i);
      end
    end
  end

endmodule

// File: rtl/generic_dff.sv
// Basic state flops shared across the codebase.
//   generic_dff     : enabled register, synchronous active-low reset to RESET_VALUE
//   generic_dff_clr : as generic_dff plus a synchronous clear that beats enable
// Ports: clock, reset_n, [clr], en, d[WIDTH], q[WIDTH]
module generic_dff #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      q <= RESET_VALUE;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

module generic_dff_clr #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      q <= RESET_VALUE;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/dfd_dst_trace_arbiter.sv
// Shares one packetizer VLT ingress among NUM_SRC trace generators.
//
// Handshake: a source presents a nonzero src_req_bytes in cycle N; the
// arbiter forwards the winner's request, and src_granted[winner] mirrors the
// packetizer's same-cycle combinational grant. A granted source must present
// its packet on src_vlt_packet/src_vlt_byte_enable in cycle N+1, when it is
// steered to pkt_vlt_packet. A source that sees no grant keeps its request
// and data; each such cycle bumps its saturating loss counter.
//
// Ports:
//   clock, reset_n                      clock, synchronous active-low reset
//   src_req_bytes/src_granted           per-source space request / grant
//   src_vlt_packet/src_vlt_byte_enable  per-source packet, one cycle after grant
//   src_flush_mode_enable/_exit         per-source flush request / release
//   src_stream_full                     broadcast of pkt_stream_full
//   pkt_*                               single packetizer ingress
//   loss_cnt_clear, loss_cnt            per-source loss counters and clear
module dfd_dst_trace_arbiter #(
  parameter int NUM_SRC          = 4,
  parameter int VLT_PACKET_WIDTH = dfd_dst_pkg::VLT_PACKET_WIDTH,
  parameter int LOSS_CNT_WIDTH   = 16
) (
  input  logic                                clock,
  input  logic                                reset_n,

  input  logic [$clog2(VLT_PACKET_WIDTH/8):0] src_req_bytes         [NUM_SRC],
  output logic                                src_granted           [NUM_SRC],
  input  logic [VLT_PACKET_WIDTH-1:0]         src_vlt_packet        [NUM_SRC],
  input  logic [VLT_PACKET_WIDTH/8-1:0]       src_vlt_byte_enable   [NUM_SRC],
  input  logic                                src_flush_mode_enable [NUM_SRC],
  output logic                                src_flush_mode_exit   [NUM_SRC],
  output logic                                src_stream_full,

  output logic [$clog2(VLT_PACKET_WIDTH/8):0] pkt_request_packet_space_in_bytes,
  input  logic                                pkt_requested_packet_space_granted,
  output logic [VLT_PACKET_WIDTH-1:0]         pkt_vlt_packet,
  output logic [VLT_PACKET_WIDTH/8-1:0]       pkt_vlt_byte_enable,
  output logic                                pkt_flush_mode_enable,
  input  logic                                pkt_flush_mode_exit,
  input  logic                                pkt_stream_full,

  input  logic                                loss_cnt_clear,
  output logic [LOSS_CNT_WIDTH-1:0]           loss_cnt              [NUM_SRC]
);

  import dfd_dst_pkg::*;

  localparam int PTR_W = $clog2(NUM_SRC);

  logic [NUM_SRC-1:0] req;
  logic [NUM_SRC-1:0] flush_en;
  logic [NUM_SRC-1:0] win_oh;
  logic [NUM_SRC-1:0] granted_v;
  logic [PTR_W-1:0]   win_idx;
  logic               win_vld;
  logic               win_granted;

  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   rr_ptr_nxt;
  logic [PTR_W-1:0]   sel_d1;
  logic               vld_d1;

  // Packed views of the per-source request and flush inputs.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      req[i]      = (src_req_bytes[i] != '0);
      flush_en[i] = src_flush_mode_enable[i];
    end
  end

  dfd_rr_pick #(
    .N     (NUM_SRC),
    .PTR_W (PTR_W)
  ) u_pick (
    .req       (req),
    .ptr       (rr_ptr),
    .prio      (flush_en),
    .grant_oh  (win_oh),
    .grant_idx (win_idx),
    .valid     (win_vld)
  );

  // Forward the winner's request; the packetizer answers in the same cycle.
  always_comb begin
    pkt_request_packet_space_in_bytes = '0;
    if (win_vld) begin
      pkt_request_packet_space_in_bytes = src_req_bytes[win_idx];
    end
  end

  assign granted_v   = win_oh & {NUM_SRC{pkt_requested_packet_space_granted}};
  assign win_granted = win_vld & pkt_requested_packet_space_granted;

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      src_granted[i] = granted_v[i];
    end
  end

  // Pointer moves just past a granted winner, including flush-priority wins,
  // so a lone requester keeps winning while the pointer cycles around it.
  assign rr_ptr_nxt = (win_idx == PTR_W'(NUM_SRC - 1)) ? '0 : win_idx + PTR_W'(1);

  generic_dff #(.WIDTH(PTR_W)) u_rr_ptr (
    .clock   (clock),
    .reset_n (reset_n),
    .en      (win_granted),
    .d       (rr_ptr_nxt),
    .q       (rr_ptr)
  );

  generic_dff #(.WIDTH(PTR_W)) u_sel_d1 (
    .clock   (clock),
    .reset_n (reset_n),
    .en      (1'b1),
    .d       (win_idx),
    .q       (sel_d1)
  );

  generic_dff #(.WIDTH(1)) u_vld_d1 (
    .clock   (clock),
    .reset_n (reset_n),
    .en      (1'b1),
    .d       (win_granted),
    .q       (vld_d1)
  );

  // Steering: outputs are forced to zero unless a granted packet is in
  // flight, so a stale sel_d1 (e.g. after reset) never reaches the packetizer.
  always_comb begin
    pkt_vlt_packet      = '0;
    pkt_vlt_byte_enable = '0;
    if (vld_d1) begin
      pkt_vlt_packet      = src_vlt_packet[sel_d1];
      pkt_vlt_byte_enable = src_vlt_byte_enable[sel_d1];
    end
  end

  // Flush: any source in flush mode puts the packetizer in flush mode. A
  // source is released only once it has no request and no packet in flight.
  assign pkt_flush_mode_enable = |flush_en;

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      src_flush_mode_exit[i] = pkt_flush_mode_exit & flush_en[i] & ~req[i] &
                               ~(vld_d1 & (sel_d1 == PTR_W'(i)));
    end
  end

  assign src_stream_full = pkt_stream_full;

  // Per-source saturating loss counters; clear wins over increment.
  for (genvar g = 0; g < NUM_SRC; g++) begin : g_loss
    logic [LOSS_CNT_WIDTH-1:0] cnt;
    logic                      inc;

    assign inc = req[g] & ~granted_v[g] & ~(&cnt);

    generic_dff_clr #(.WIDTH(LOSS_CNT_WIDTH)) u_cnt (
      .clock   (clock),
      .reset_n (reset_n),
      .clr     (loss_cnt_clear),
      .en      (inc),
      .d       (cnt + LOSS_CNT_WIDTH'(1)),
      .q       (cnt)
    );

    assign loss_cnt[g] = cnt;
  end

endmodule

// File: tb/tb_dfd_dst_trace_arbiter.sv
// Directed self-checking bench for dfd_dst_trace_arbiter (NUM_SRC=4,
// 64-bit packets, 16-bit loss counters). Inputs change 1 time unit after the
// rising edge; combinational outputs are sampled one more unit later.
module tb_dfd_dst_trace_arbiter;

  localparam int N   = 4;
  localparam int PW  = 64;
  localparam int BEW = PW / 8;
  localparam int RQW = $clog2(BEW) + 1;
  localparam int LW  = 16;

  logic           clock;
  logic           reset_n;
  logic [RQW-1:0] src_req_bytes         [N];
  logic           src_granted           [N];
  logic [PW-1:0]  src_vlt_packet        [N];
  logic [BEW-1:0] src_vlt_byte_enable   [N];
  logic           src_flush_mode_enable [N];
  logic           src_flush_mode_exit   [N];
  logic           src_stream_full;
  logic [RQW-1:0] pkt_request_packet_space_in_bytes;
  logic           pkt_requested_packet_space_granted;
  logic [PW-1:0]  pkt_vlt_packet;
  logic [BEW-1:0] pkt_vlt_byte_enable;
  logic           pkt_flush_mode_enable;
  logic           pkt_flush_mode_exit;
  logic           pkt_stream_full;
  logic           loss_cnt_clear;
  logic [LW-1:0]  loss_cnt              [N];

  int n_total;
  int n_bad;
  int exp_ptr;

  dfd_dst_trace_arbiter #(
    .NUM_SRC          (N),
    .VLT_PACKET_WIDTH (PW),
    .LOSS_CNT_WIDTH   (LW)
  ) dut (
    .clock                              (clock),
    .reset_n                            (reset_n),
    .src_req_bytes                      (src_req_bytes),
    .src_granted                        (src_granted),
    .src_vlt_packet                     (src_vlt_packet),
    .src_vlt_byte_enable                (src_vlt_byte_enable),
    .src_flush_mode_enable              (src_flush_mode_enable),
    .src_flush_mode_exit                (src_flush_mode_exit),
    .src_stream_full                    (src_stream_full),
    .pkt_request_packet_space_in_bytes  (pkt_request_packet_space_in_bytes),
    .pkt_requested_packet_space_granted (pkt_requested_packet_space_granted),
    .pkt_vlt_packet                     (pkt_vlt_packet),
    .pkt_vlt_byte_enable                (pkt_vlt_byte_enable),
    .pkt_flush_mode_enable              (pkt_flush_mode_enable),
    .pkt_flush_mode_exit                (pkt_flush_mode_exit),
    .pkt_stream_full                    (pkt_stream_full),
    .loss_cnt_clear                     (loss_cnt_clear),
    .loss_cnt                           (loss_cnt)
  );

  // ---------------- clock ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- helpers ----------------
  function automatic logic [PW-1:0] pkt_of(input int i);
    logic [7:0] tag;
    tag = 8'(i);
    return {16'hC0DE, 40'h0, tag};
  endfunction

  function automatic logic [BEW-1:0] be_of(input int i);
    return 8'hF0 | 8'(i + 1);
  endfunction

  function automatic logic [N-1:0] gnt_vec();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = src_granted[i];
    return v;
  endfunction

  function automatic logic [N-1:0] fexit_vec();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = src_flush_mode_exit[i];
    return v;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
    end
  endtask

  // Advance to 1 unit after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_req(input logic [N-1:0] mask, input logic [RQW-1:0] bytes);
    for (int i = 0; i < N; i++) src_req_bytes[i] = mask[i] ? bytes : '0;
  endtask

  task automatic set_flush(input logic [N-1:0] mask);
    for (int i = 0; i < N; i++) src_flush_mode_enable[i] = mask[i];
  endtask

  task automatic check_all_loss(input string tag, input logic [LW-1:0] exp);
    for (int i = 0; i < N; i++) check($sformatf("%s[%0d]", tag, i), 64'(loss_cnt[i]), 64'(exp));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_total = 0;
    n_bad   = 0;
    reset_n = 1'b0;
    pkt_requested_packet_space_granted = 1'b1;
    pkt_flush_mode_exit = 1'b0;
    pkt_stream_full     = 1'b0;
    loss_cnt_clear      = 1'b0;
    for (int i = 0; i < N; i++) begin
      src_vlt_packet[i]      = pkt_of(i);
      src_vlt_byte_enable[i] = be_of(i);
    end
    set_req(4'b0000, 4'd0);
    set_flush(4'b0000);

    // ---- reset state ----
    tick();
    tick();
    reset_n = 1'b1;
    settle();
    check("rst_be", 64'(pkt_vlt_byte_enable), 64'h0);
    check("rst_pkt", pkt_vlt_packet, 64'h0);
    check("rst_gnt", 64'(gnt_vec()), 64'h0);
    check("rst_fexit", 64'(fexit_vec()), 64'h0);
    check("rst_req_fwd", 64'(pkt_request_packet_space_in_bytes), 64'h0);
    check_all_loss("rst_loss", 16'h0);

    // ---- stream full passthrough ----
    pkt_stream_full = 1'b1;
    settle();
    check("sfull_1", 64'(src_stream_full), 64'h1);
    pkt_stream_full = 1'b0;
    settle();
    check("sfull_0", 64'(src_stream_full), 64'h0);

    // ---- round robin, all request 8 bytes, grant always 1 ----
    exp_ptr = 0;
    tick();
    set_req(4'b1111, 4'd8);
    settle();
    for (int k = 0; k < 8; k++) begin
      check($sformatf("rr_gnt%0d", k), 64'(gnt_vec()), 64'(1 << exp_ptr));
      check($sformatf("rr_fwd%0d", k), 64'(pkt_request_packet_space_in_bytes), 64'd8);
      if (k > 0) begin
        check($sformatf("rr_pkt%0d", k), pkt_vlt_packet, pkt_of((exp_ptr + N - 1) % N));
        check($sformatf("rr_be%0d", k), 64'(pkt_vlt_byte_enable), 64'(be_of((exp_ptr + N - 1) % N)));
      end
      exp_ptr = (exp_ptr + 1) % N;
      tick();
      settle();
    end
    // Last winner (source 3) is in flight now; each source lost 6 of 8.
    check("rr_pkt_last", pkt_vlt_packet, pkt_of(3));
    check_all_loss("rr_loss", 16'd6);

    // clear counters, idle
    set_req(4'b0000, 4'd0);
    loss_cnt_clear = 1'b1;
    tick();
    loss_cnt_clear = 1'b0;
    settle();
    check_all_loss("clr_loss", 16'd0);
    check("idle_be", 64'(pkt_vlt_byte_enable), 64'h0);

    // ---- packetizer deny: sources 1,2 for 2 cycles (ptr is 0) ----
    set_req(4'b0110, 4'd8);
    pkt_requested_packet_space_granted = 1'b0;
    settle();
    check("deny_gnt0", 64'(gnt_vec()), 64'h0);
    check("deny_fwd0", 64'(pkt_request_packet_space_in_bytes), 64'd8);
    tick();
    settle();
    check("deny_gnt1", 64'(gnt_vec()), 64'h0);
    check("deny_be1", 64'(pkt_vlt_byte_enable), 64'h0);
    tick();
    pkt_requested_packet_space_granted = 1'b1;
    settle();
    check("deny_be2", 64'(pkt_vlt_byte_enable), 64'h0);
    check("deny_loss1", 64'(loss_cnt[1]), 64'd2);
    check("deny_loss2", 64'(loss_cnt[2]), 64'd2);
    check("deny_loss0", 64'(loss_cnt[0]), 64'd0);
    // pointer held at 0, so source 1 wins first, then source 2
    check("deny_ptr_hold", 64'(gnt_vec()), 64'b0010);
    tick();
    settle();
    check("deny_next", 64'(gnt_vec()), 64'b0100);
    check("deny_next_pkt", pkt_vlt_packet, pkt_of(1));
    tick();
    set_req(4'b0000, 4'd0);
    loss_cnt_clear = 1'b1;
    settle();
    check("deny_last_pkt", pkt_vlt_packet, pkt_of(2));
    tick();
    loss_cnt_clear = 1'b0;

    // ---- flush priority (ptr is 3) ----
    set_req(4'b1000, 4'd4);   // source 3 alone -> ptr becomes 0
    settle();
    check("fl_pre_gnt", 64'(gnt_vec()), 64'b1000);
    tick();
    set_req(4'b1001, 4'd4);
    set_flush(4'b1000);
    settle();
    check("fl_gnt", 64'(gnt_vec()), 64'b1000);
    check("fl_en", 64'(pkt_flush_mode_enable), 64'h1);
    tick();
    pkt_flush_mode_exit = 1'b1;
    settle();
    check("fl_gnt2", 64'(gnt_vec()), 64'b1000);
    check("fl_exit_req", 64'(fexit_vec()), 64'h0);
    tick();
    set_req(4'b0001, 4'd4);   // source 3 stops; its last packet is in flight
    settle();
    check("fl_gnt3", 64'(gnt_vec()), 64'b0001);
    check("fl_inflight_pkt", pkt_vlt_packet, pkt_of(3));
    check("fl_exit_inflight", 64'(fexit_vec()), 64'h0);
    tick();
    set_req(4'b0000, 4'd0);
    settle();
    check("fl_exit", 64'(fexit_vec()), 64'b1000);
    tick();
    set_flush(4'b0000);
    pkt_flush_mode_exit = 1'b0;
    settle();
    check("fl_en_off", 64'(pkt_flush_mode_enable), 64'h0);
    check("fl_exit_off", 64'(fexit_vec()), 64'h0);
    // ptr is now 1

    // ---- loss counter saturation and clear ----
    loss_cnt_clear = 1'b1;
    tick();
    loss_cnt_clear = 1'b0;
    set_req(4'b0001, 4'd8);
    pkt_requested_packet_space_granted = 1'b0;
    for (int k = 0; k < 16'hFFFE; k++) tick();
    settle();
    check("sat_fffe", 64'(loss_cnt[0]), 64'hFFFE);
    tick();
    settle();
    check("sat_ffff", 64'(loss_cnt[0]), 64'hFFFF);
    tick();
    tick();
    settle();
    check("sat_hold", 64'(loss_cnt[0]), 64'hFFFF);
    loss_cnt_clear = 1'b1;
    tick();
    loss_cnt_clear = 1'b0;
    settle();
    check("sat_clr", 64'(loss_cnt[0]), 64'h0);
    set_req(4'b0000, 4'd0);
    pkt_requested_packet_space_granted = 1'b1;
    tick();

    // ---- reset mid-transfer (ptr is 1) ----
    set_req(4'b0110, 4'd8);   // winner 1, source 2 loses, ptr -> 2
    settle();
    check("mr_gnt1", 64'(gnt_vec()), 64'b0010);
    tick();
    set_req(4'b1100, 4'd8);   // winner 2, source 3 loses, ptr -> 3
    settle();
    check("mr_gnt2", 64'(gnt_vec()), 64'b0100);
    tick();
    set_req(4'b0000, 4'd0);
    reset_n = 1'b0;
    settle();
    check("mr_inflight_be", 64'(pkt_vlt_byte_enable), 64'(be_of(2)));
    check("mr_loss2_pre", 64'(loss_cnt[2]), 64'd1);
    tick();
    reset_n = 1'b1;
    settle();
    check("mr_be", 64'(pkt_vlt_byte_enable), 64'h0);
    check("mr_pkt", pkt_vlt_packet, 64'h0);
    check_all_loss("mr_loss", 16'd0);
    set_req(4'b1001, 4'd8);   // ptr back at 0 -> source 0 wins
    settle();
    check("mr_ptr0", 64'(gnt_vec()), 64'b0001);
    tick();
    set_req(4'b0000, 4'd0);
    settle();
    check("mr_after_pkt", pkt_vlt_packet, pkt_of(0));
    tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
